// File: rtl/coprocessor_fetch.sv
// rtl/coprocessor_fetch.sv - streams LEN RAM words from a PIO base address into a buffered valid/ready stream
// Optional bound check enabled by defining COPROC_FETCH_BOUND_EN.
module coprocessor_fetch #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [LEN_W-1:0]  len_in,
  input  logic              start_in,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t             state, state_n;
  logic [ADDR_W-1:0]  cur_addr, cur_addr_n;
  logic [LEN_W-1:0]   remaining, remaining_n;
  logic               start_q, inflight;
  logic               done_q, done_n, err_q, err_n;
  logic [DATA_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   fifo_count;
  logic               start_edge, issue, push, pop, bound_bad;

  assign start_edge = start_in & ~start_q;
  assign push       = inflight;
  assign pop        = out_valid & out_ready;

  // A read already in flight owns a FIFO slot; pops this cycle are not credited.
  assign issue = (state == S_FETCH) && (remaining != '0) &&
                 ((fifo_count + CNT_W'(inflight)) < DEPTH_C);

`ifdef COPROC_FETCH_BOUND_EN
  localparam int SUM_W = ADDR_W + LEN_W + 1;
  logic [SUM_W-1:0] end_addr;
  assign end_addr  = SUM_W'(addr_in) + SUM_W'(len_in);
  assign bound_bad = end_addr > (SUM_W'(1) << ADDR_W);
`else
  assign bound_bad = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_n;
      cur_addr  <= cur_addr_n;
      remaining <= remaining_n;
      done_q    <= done_n;
      err_q     <= err_n;
    end
  end

  always_comb begin
    state_n     = state;
    cur_addr_n  = cur_addr;
    remaining_n = remaining;
    done_n      = 1'b0;
    err_n       = err_q;
    case (state)
      S_IDLE: begin
        if (start_edge) begin
          err_n = 1'b0;
          if (bound_bad) begin
            err_n  = 1'b1;
            done_n = 1'b1;
          end else if (len_in == '0) begin
            done_n = 1'b1;
          end else begin
            cur_addr_n  = addr_in;
            remaining_n = len_in;
            state_n     = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        if (issue) begin
          cur_addr_n  = cur_addr + ADDR_W'(1);
          remaining_n = remaining - LEN_W'(1);
          if (remaining == LEN_W'(1)) state_n = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!inflight && (fifo_count == '0)) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_q    <= 1'b0;
      inflight   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      start_q  <= start_in;
      inflight <= issue;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_readdata;
  end

  assign mem_read    = issue;
  assign mem_address = cur_addr;
  assign out_valid   = (fifo_count != '0);
  assign out_data    = out_valid ? fifo_mem[rd_ptr] : '0;
  assign busy        = (state != S_IDLE);
  assign done        = done_q;
  assign error       = err_q;

endmodule

// File: tb/tb_coprocessor_fetch.sv
// tb/tb_coprocessor_fetch.sv - directed self-checking bench for coprocessor_fetch
module tb_coprocessor_fetch;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [14:0] addr_in = '0;
  logic [15:0] len_in = '0;
  logic        start_in = 1'b0;
  logic [14:0] mem_address;
  logic        mem_read;
  logic [31:0] mem_readdata = '0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        busy, done, error;

  coprocessor_fetch dut (
    .clk(clk), .reset_n(reset_n), .addr_in(addr_in), .len_in(len_in),
    .start_in(start_in), .mem_address(mem_address), .mem_read(mem_read),
    .mem_readdata(mem_readdata), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [0:32767];
  initial for (int i = 0; i < 32768; i++) ram[i] = 32'(i * 3);
  always @(posedge clk) if (mem_read) mem_readdata <= ram[mem_address];

  function automatic logic [31:0] exp_word(input int a);
    return 32'((a % 32768) * 3);
  endfunction

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  logic [31:0] pop_q[$];
  logic [14:0] addr_q[$];
  int done_cnt = 0, valid_bad = 0, credit_bad = 0, stall_bad = 0, max_credit = 0;
  int occ = 0, infl = 0;
  bit hold = 0;
  logic [31:0] hold_data = '0;

  // Reference occupancy model plus stream observers, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset_n) begin
      occ = 0; infl = 0; hold = 0;
    end else begin
      if (out_valid && out_ready) pop_q.push_back(out_data);
      if (mem_read) addr_q.push_back(mem_address);
      if (done) done_cnt++;
      if (out_valid !== (occ != 0)) valid_bad++;
      if (mem_read && (occ + infl >= 4)) credit_bad++;
      if (occ + infl > max_credit) max_credit = occ + infl;
      if (hold && (out_data !== hold_data)) stall_bad++;
      hold = out_valid && !out_ready;
      hold_data = out_data;
      occ = occ + infl - ((out_valid && out_ready) ? 1 : 0);
      infl = mem_read ? 1 : 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    pop_q.delete(); addr_q.delete();
    done_cnt = 0; valid_bad = 0; credit_bad = 0; stall_bad = 0; max_credit = 0;
  endtask

  task automatic pulse_start(input logic [14:0] a, input logic [15:0] l);
    addr_in = a; len_in = l; start_in = 1'b1;
    tick(1);
    start_in = 1'b0;
  endtask

  task automatic wait_done(input bit toggle, input int budget);
    int d0 = done_cnt;
    int i = 0;
    while (done_cnt == d0 && i < budget) begin
      if (toggle) out_ready = ~out_ready;
      tick(1);
      i++;
    end
    check("done_timeout", 64'(done_cnt != d0), 64'd1);
    out_ready = 1'b1;
    tick(3);
  endtask

  task automatic check_words(input string tag, input int base, input int n);
    check({tag, "_count"}, 64'(pop_q.size()), 64'(n));
    for (int i = 0; i < n && i < pop_q.size(); i++)
      check({tag, "_word"}, 64'(pop_q[i]), 64'(exp_word(base + i)));
  endtask

  initial begin
    tick(2);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_mem_read", 64'(mem_read), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_addr", 64'(mem_address), 64'd0);
    reset_n = 1'b1;
    tick(2);

    // basic 4-word transfer with latency checks
    clear_obs();
    pulse_start(15'h0010, 16'd4);
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_mem_read", 64'(mem_read), 64'd1);
    check("t1_mem_addr", 64'(mem_address), 64'h10);
    tick(1);
    check("t1_valid_early", 64'(out_valid), 64'd0);
    tick(1);
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_first", 64'(out_data), 64'h30);
    check("t1_busy_mid", 64'(busy), 64'd1);
    wait_done(1'b0, 50);
    check_words("t1", 16'h10, 4);
    check("t1_done_cnt", 64'(done_cnt), 64'd1);
    check("t1_busy_after", 64'(busy), 64'd0);

    // zero length, start held high for several cycles
    clear_obs();
    addr_in = 15'h0055; len_in = 16'd0; start_in = 1'b1;
    tick(1);
    check("t2_done", 64'(done), 64'd1);
    check("t2_busy", 64'(busy), 64'd0);
    tick(3);
    start_in = 1'b0;
    tick(2);
    check("t2_done_cnt", 64'(done_cnt), 64'd1);
    check("t2_no_read", 64'(addr_q.size()), 64'd0);

    // backpressure with out_ready toggling
    clear_obs();
    pulse_start(15'h0000, 16'd8);
    wait_done(1'b1, 200);
    check_words("t3", 0, 8);
    check("t3_reads", 64'(addr_q.size()), 64'd8);
    check("t3_max_credit", 64'(max_credit), 64'd4);
    check("t3_credit_bad", 64'(credit_bad), 64'd0);
    check("t3_stall_bad", 64'(stall_bad), 64'd0);
    check("t3_valid_bad", 64'(valid_bad), 64'd0);

    // top-of-memory transfer
    clear_obs();
    pulse_start(15'h7FFE, 16'd3);
    wait_done(1'b0, 50);
    check("t4_done_cnt", 64'(done_cnt), 64'd1);
`ifdef COPROC_FETCH_BOUND_EN
    check("t4_error", 64'(error), 64'd1);
    check("t4_no_read", 64'(addr_q.size()), 64'd0);
    check("t4_no_words", 64'(pop_q.size()), 64'd0);
`else
    check("t4_error", 64'(error), 64'd0);
    check("t4_reads", 64'(addr_q.size()), 64'd3);
    if (addr_q.size() == 3) begin
      check("t4_addr0", 64'(addr_q[0]), 64'h7FFE);
      check("t4_addr1", 64'(addr_q[1]), 64'h7FFF);
      check("t4_addr2", 64'(addr_q[2]), 64'h0000);
    end
    check_words("t4", 15'h7FFE, 3);
`endif

    // second start edge while busy is ignored
    clear_obs();
    pulse_start(15'h0040, 16'd16);
    tick(3);
    addr_in = 15'h0100; len_in = 16'd5; start_in = 1'b1;
    tick(1);
    start_in = 1'b0;
    wait_done(1'b0, 100);
    check_words("t5", 16'h40, 16);
    check("t5_done_cnt", 64'(done_cnt), 64'd1);
    check("t5_error", 64'(error), 64'd0);

    // reset in the middle of a transfer, then a fresh transfer
    clear_obs();
    pulse_start(15'h0200, 16'd16);
    for (int i = 0; i < 100 && pop_q.size() < 5; i++) tick(1);
    check("t6_five_words", 64'(pop_q.size() >= 5), 64'd1);
    reset_n = 1'b0;
    #1;
    check("t6_rst_valid", 64'(out_valid), 64'd0);
    check("t6_rst_busy", 64'(busy), 64'd0);
    check("t6_rst_done", 64'(done), 64'd0);
    check("t6_rst_read", 64'(mem_read), 64'd0);
    tick(1);
    reset_n = 1'b1;
    tick(1);
    check("t6_no_done", 64'(done_cnt), 64'd0);
    clear_obs();
    pulse_start(15'h0020, 16'd2);
    wait_done(1'b0, 50);
    check_words("t6", 16'h20, 2);
    check("t6_done_cnt", 64'(done_cnt), 64'd1);
    check("t6_valid_bad", 64'(valid_bad), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/coprocessor_fetch.md
Name: coprocessor_fetch

Overview:
- Downstream consumer of the coprocessor address PIO.
- Takes the 15-bit base address driven by that PIO, plus a word count and a start bit from a companion control PIO.
- Streams LEN consecutive words out of the coprocessor's synchronous on-chip RAM into a valid/ready stream feeding the coprocessor datapath.
- Buffers read data in a small FIFO, so downstream backpressure never drops a word that is already in flight.

Parameters:
ADDR_W, 15, RAM word-address width (matches PIO out_port width)
DATA_W, 32, RAM/stream data width
LEN_W, 16, transfer-length width in words
FIFO_DEPTH, 4, output buffer entries; power of 2, >=4 for full rate

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
addr_in  in  ADDR_W  base word address from address PIO out_port
len_in  in  LEN_W  word count from control PIO
start_in  in  1  start level from control PIO; rising edge triggers transfer
mem_address  out  ADDR_W  RAM read address
mem_read  out  1  RAM read strobe; data returns exactly 1 cycle later
mem_readdata  in  DATA_W  RAM read data
out_data  out  DATA_W  stream data (FIFO head)
out_valid  out  1  stream valid
out_ready  in  1  stream ready from coprocessor
busy  out  1  transfer in progress
done  out  1  one-cycle pulse at transfer completion
error  out  1  bound violation flag (COPROC_FETCH_BOUND_EN only, else tied 0)

Behaviour:
- Reset:
  - Single clock clk; asynchronous active-low reset reset_n.
  - All outputs 0 while reset_n=0. FIFO emptied, in-flight read discarded, state=IDLE, start edge register=0.
  - Reset mid-transfer aborts it with no done pulse.
- Start detection:
  - start_in is registered each cycle; start_edge = start_in & ~start_q.
  - Held-high start_in triggers only once.
- State IDLE:
  - On start_edge with len_in!=0: latch cur_addr=addr_in, remaining=len_in; busy=1 next cycle; go FETCH.
  - On start_edge with len_in==0: done=1 next cycle; stay IDLE; no mem_read.
- State FETCH:
  - Asserts mem_read with mem_address=cur_addr when remaining!=0 and (fifo_count + inflight) < FIFO_DEPTH. Pops in the same cycle are not credited.
  - Each issue: cur_addr+1 modulo 2^ADDR_W (wraps 0x7FFF->0x0000), remaining-1, inflight=1 for the next cycle.
  - Issue of the last word -> DRAIN.
- State DRAIN: when inflight=0 and fifo_count=0 -> IDLE; busy=0 and done=1 on the same cycle.
- Data capture: mem_readdata is pushed into the FIFO on the cycle after mem_read. The credit rule guarantees no overflow.
- Stream output:
  - out_valid = fifo_count!=0; out_data = head.
  - Pop on out_valid & out_ready; push and pop may occur in the same cycle.
  - out_data must stay stable while out_valid & ~out_ready.
- Latency and rate:
  - start edge sampled at cycle N: first mem_read at N+1, data written at N+2, out_valid at N+2 (combinational from FIFO count after write).
  - 1 word/cycle sustained with out_ready=1.
- Inputs while busy: start_edge ignored (start_q still updated); addr_in/len_in changes ignored.
- Words are delivered in ascending address order, exactly len words, none duplicated.

Optional Feature:
Macro COPROC_FETCH_BOUND_EN.
- Defined:
  - At start, if addr_in + len_in > 2^ADDR_W (compute at ADDR_W+LEN_W+1 bits): no fetch, error=1, done pulse next cycle.
  - error stays set until the next accepted start_edge or reset.
  - Legal transfers never wrap.
- Not defined: no check; address wraps modulo 2^ADDR_W; error output tied 0.

Test Plan:
- addr_in=0x0010, len_in=4, RAM[i]=i*3, out_ready=1, start pulse -> out_data 0x30,0x33,0x36,0x39 on 4 consecutive cycles; done pulse once; busy 1 throughout, 0 after.
- len_in=0, start pulse -> done pulse one cycle later; mem_read never asserted; busy stays 0.
- addr_in=0x0000, len_in=8, out_ready toggling 1/0 every cycle -> all 8 words in order, none lost or duplicated; mem_read stalls once 4 entries are credited; out_data stable while stalled.
- Without macro: addr_in=0x7FFE, len_in=3 -> mem_address 0x7FFE,0x7FFF,0x0000. With COPROC_FETCH_BOUND_EN: same stimulus -> error=1, done pulse, no mem_read.
- Second start edge during a len=16 transfer, addr_in changed to 0x0100 -> ignored; 16 words from the original base only.
- reset_n low for 1 cycle mid-transfer after 5 words -> out_valid/busy/done 0 immediately; new start with addr 0x0020, len 2 -> exactly 2 correct words.
